vend_sequencer: RTL and testbench
=================================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter ITEM_ADDR, default 10, meaning item index width.
REQ-002 SHALL have parameter NO_ITEMS_ADDR, default 8, meaning count and price width.
REQ-003 SHALL have parameter AMOUNT_W, default 16, meaning money accumulator width.
REQ-004 SHALL have parameter LOOKUP_LAT, default 3, meaning cycles from item_id change to valid avail_count/item_price.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1000, meaning idle cycles allowed in COLLECT before refund.
REQ-006 SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
REQ-007 SHALL have these ports:
- cfg_mode  in  1  table being configured; vending blocked.
- sel_valid  in  1  one-cycle purchase request strobe.
- sel_id  in  ITEM_ADDR  requested item.
- sel_qty  in  NO_ITEMS_ADDR  requested quantity.
- coin_valid  in  1  one-cycle coin strobe.
- coin_value  in  8  coin value.
- cancel  in  1  user abort, level-sampled.
- item_id  out  ITEM_ADDR  registered table lookup index.
- avail_count  in  NO_ITEMS_ADDR  table stock for item_id.
- item_price  in  NO_ITEMS_ADDR  table unit price for item_id.
- dispense_valid  out  1  one-cycle table decrement strobe.
- no_items_dispensed  out  NO_ITEMS_ADDR  quantity dispensed.
- coin_reject  out  1  coin returned immediately.
- change_valid  out  1  one-cycle change/refund strobe.
- change_amount  out  AMOUNT_W  change or refund value.
- err_valid  out  1  one-cycle error strobe.
- err_code  out  2  1=SOLD_OUT, 2=BAD_QTY, 3=TIMEOUT/CANCEL.
- busy  out  1  state != IDLE.

Function
REQ-008 SHALL implement the states IDLE, LOOKUP, CHECK, COLLECT, DISPENSE, SETTLE, and CHANGE.
REQ-009 IDLE: on sel_valid with cfg_mode=0, SHALL latch sel_id into item_id and sel_qty into qty_r, clear the paid register, and go to LOOKUP; SHALL ignore sel_valid while cfg_mode=1.
REQ-010 LOOKUP: SHALL count LOOKUP_LAT cycles and then go to CHECK; SHALL hold item_id constant from LOOKUP through SETTLE.
REQ-011 CHECK: SHALL compute cost = item_price*qty_r zero-extended to AMOUNT_W, with no overflow since 8x8 bits fit in 16 bits.
REQ-012 CHECK: qty_r==0 SHALL pulse err BAD_QTY and go to IDLE; otherwise qty_r>avail_count SHALL pulse err SOLD_OUT and go to IDLE; otherwise cost==0 SHALL go to DISPENSE; otherwise SHALL go to COLLECT.
REQ-013 COLLECT: each coin_valid SHALL add coin_value to paid, saturating at 2^AMOUNT_W-1, and reset the timeout counter.
REQ-014 COLLECT: when paid>=cost, including on the coin cycle's registered result, SHALL go to DISPENSE.
REQ-015 COLLECT: cancel, timeout (counter==TIMEOUT_CYC-1), or cfg_mode=1 SHALL pulse err code 3 and go to CHANGE with change_amount=paid; priority is cancel/cfg_mode over completion in the same cycle.
REQ-016 DISPENSE: SHALL assert dispense_valid for exactly one cycle with no_items_dispensed=qty_r and go to SETTLE.
REQ-017 SETTLE: SHALL wait LOOKUP_LAT cycles so the table's stock pipeline reflects the decrement, then go to CHANGE.
REQ-018 CHANGE: SHALL pulse change_valid once with change_amount=paid-cost (or the refund), then go to IDLE; SHALL suppress the pulse when the amount is 0.
REQ-019 coin_valid in any state other than COLLECT SHALL pulse coin_reject next cycle and SHALL NOT change paid.
REQ-020 sel_valid outside IDLE SHALL be ignored.
REQ-021 All outputs SHALL be registered; strobes SHALL be high for one cycle only.

Reset
REQ-022 rst SHALL force IDLE and zero item_id, qty_r, paid, counters, no_items_dispensed, and change_amount.
REQ-023 rst SHALL deassert all strobes, force err_code=0, and force busy=0.
REQ-024 rst mid-transaction SHALL discard it with no dispense and no change pulse.

Structure
REQ-025 A shared vend_pkg SHALL hold the state enum, the err_code constants, and the width defaults.
REQ-026 The timeout/latency down-counter SHALL be a sub-module vend_timer, reused for LOOKUP, SETTLE, and COLLECT timeout.

Verification
REQ-027 Exact payment: price=5, avail=3, qty=2, coins 5,5 -> one dispense_valid with no_items_dispensed=2, no change_valid, table avail=1.
REQ-028 Overpay: price=7, qty=1, coin 10 -> dispense qty 1, then change_valid with change_amount=3.
REQ-029 Sold out: avail=1, qty=2 -> err_valid with err_code=1, no dispense, busy returns low.
REQ-030 Cancel: price=20, coins 5,5, cancel -> err_code=3, change_valid with change_amount=10, no dispense.
REQ-031 Timeout: coin 5 then idle for TIMEOUT_CYC cycles -> refund 5, err_code=3.
REQ-032 Misc: coin in IDLE -> coin_reject; rst during COLLECT -> IDLE, no strobes; qty=0 -> err_code=2.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared states, error codes and width defaults for the vending sequencer
package vend_pkg;
   localparam int DEF_ITEM_ADDR = 10;
   localparam int DEF_NO_ITEMS_ADDR = 8;
   localparam int DEF_AMOUNT_W = 16;
   localparam int DEF_LOOKUP_LAT = 3;
   localparam int DEF_TIMEOUT_CYC = 1000;
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_CHECK,
      S_COLLECT,
      S_DISPENSE,
      S_SETTLE,
      S_CHANGE
   } state_t;
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_SOLD_OUT = 2'd1;
   localparam logic [1:0] ERR_BAD_QTY = 2'd2;
   localparam logic [1:0] ERR_ABORT = 2'd3;
endpackage

// File: rtl/vend_sequencer_if.sv
// vend_sequencer_if: purchase, coin, table-lookup and result signals of the sequencer
interface vend_sequencer_if
   import vend_pkg::*;
#(
   parameter int ITEM_ADDR = DEF_ITEM_ADDR,
   parameter int NO_ITEMS_ADDR = DEF_NO_ITEMS_ADDR,
   parameter int AMOUNT_W = DEF_AMOUNT_W
) ();
   logic cfg_mode;
   logic sel_valid;
   logic [ITEM_ADDR-1:0] sel_id;
   logic [NO_ITEMS_ADDR-1:0] sel_qty;
   logic coin_valid;
   logic [7:0] coin_value;
   logic cancel;
   logic [ITEM_ADDR-1:0] item_id;
   logic [NO_ITEMS_ADDR-1:0] avail_count;
   logic [NO_ITEMS_ADDR-1:0] item_price;
   logic dispense_valid;
   logic [NO_ITEMS_ADDR-1:0] no_items_dispensed;
   logic coin_reject;
   logic change_valid;
   logic [AMOUNT_W-1:0] change_amount;
   logic err_valid;
   logic [1:0] err_code;
   logic busy;
   modport slave (
      input cfg_mode, sel_valid, sel_id, sel_qty, coin_valid, coin_value, cancel,
      input avail_count, item_price,
      output item_id, dispense_valid, no_items_dispensed, coin_reject,
      output change_valid, change_amount, err_valid, err_code, busy
   );
   modport master (
      output cfg_mode, sel_valid, sel_id, sel_qty, coin_valid, coin_value, cancel,
      output avail_count, item_price,
      input item_id, dispense_valid, no_items_dispensed, coin_reject,
      input change_valid, change_amount, err_valid, err_code, busy
   );
endinterface

// File: rtl/vend_timer.sv
// vend_timer: loadable down-counter that parks at zero; done while the count is zero
module vend_timer #(
   parameter int W = 10
) (
   input logic clk,
   input logic rst,
   input logic load,
   input logic [W-1:0] load_val,
   output logic done
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - W'(1);
   end
   assign done = cnt == '0;
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: purchase sequencer driving a pipelined stock/price table
// Outputs are registered from the next state so strobes coincide with their state.
module vend_sequencer
   import vend_pkg::*;
#(
   parameter int ITEM_ADDR = DEF_ITEM_ADDR,
   parameter int NO_ITEMS_ADDR = DEF_NO_ITEMS_ADDR,
   parameter int AMOUNT_W = DEF_AMOUNT_W,
   parameter int LOOKUP_LAT = DEF_LOOKUP_LAT,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input logic clk,
   input logic rst,
   vend_sequencer_if.slave bus
);
   localparam int TW = $clog2((TIMEOUT_CYC > LOOKUP_LAT ? TIMEOUT_CYC : LOOKUP_LAT) + 1);
   localparam int PW = 2 * NO_ITEMS_ADDR;
   state_t state, nxt;
   logic [ITEM_ADDR-1:0] id_r;
   logic [NO_ITEMS_ADDR-1:0] qty_r;
   logic [AMOUNT_W-1:0] paid, paid_nxt, cost_r, cost_c, due_nxt;
   logic [AMOUNT_W:0] sum_ext;
   logic [PW-1:0] prod;
   logic [TW-1:0] t_val;
   logic [1:0] err_nxt;
   logic t_load, t_done, start, abort;
   assign start = state == S_IDLE && bus.sel_valid && !bus.cfg_mode;
   assign prod = PW'(bus.item_price) * PW'(qty_r);
   assign cost_c = AMOUNT_W'(prod);
   assign sum_ext = {1'b0, paid} + (AMOUNT_W + 1)'(bus.coin_value);
   assign paid_nxt = !(state == S_COLLECT && bus.coin_valid) ? paid
                   : sum_ext[AMOUNT_W] ? '1 : sum_ext[AMOUNT_W-1:0];
   // without a coin paid is still short of cost, so timeout never races completion
   assign abort = bus.cancel || bus.cfg_mode || (t_done && !bus.coin_valid);
   assign bus.item_id = id_r;
   vend_timer #(.W(TW)) u_timer (
      .clk(clk),
      .rst(rst),
      .load(t_load),
      .load_val(t_val),
      .done(t_done)
   );
   always_comb begin
      nxt = state;
      t_load = 1'b0;
      t_val = TW'(LOOKUP_LAT - 1);
      err_nxt = ERR_NONE;
      due_nxt = '0;
      case (state)
         S_IDLE: if (start) begin
            nxt = S_LOOKUP;
            t_load = 1'b1;
         end
         S_LOOKUP: nxt = t_done ? S_CHECK : S_LOOKUP;
         S_CHECK: begin
            if (qty_r == '0) begin
               nxt = S_IDLE;
               err_nxt = ERR_BAD_QTY;
            end else if (qty_r > bus.avail_count) begin
               nxt = S_IDLE;
               err_nxt = ERR_SOLD_OUT;
            end else if (cost_c == '0) nxt = S_DISPENSE;
            else begin
               nxt = S_COLLECT;
               t_load = 1'b1;
               t_val = TW'(TIMEOUT_CYC - 1);
            end
         end
         S_COLLECT: begin
            t_load = bus.coin_valid;
            t_val = TW'(TIMEOUT_CYC - 1);
            if (abort) begin
               nxt = S_CHANGE;
               err_nxt = ERR_ABORT;
               due_nxt = paid_nxt;
            end else if (paid_nxt >= cost_r) nxt = S_DISPENSE;
         end
         S_DISPENSE: begin
            nxt = S_SETTLE;
            t_load = 1'b1;
         end
         S_SETTLE: if (t_done) begin
            nxt = S_CHANGE;
            due_nxt = paid - cost_r;
         end
         S_CHANGE: nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         id_r <= '0;
         qty_r <= '0;
         paid <= '0;
         cost_r <= '0;
         bus.dispense_valid <= 1'b0;
         bus.no_items_dispensed <= '0;
         bus.coin_reject <= 1'b0;
         bus.change_valid <= 1'b0;
         bus.change_amount <= '0;
         bus.err_valid <= 1'b0;
         bus.err_code <= ERR_NONE;
         bus.busy <= 1'b0;
      end else begin
         state <= nxt;
         if (start) begin
            id_r <= bus.sel_id;
            qty_r <= bus.sel_qty;
         end
         paid <= start ? '0 : paid_nxt;
         if (state == S_CHECK) cost_r <= cost_c;
         bus.dispense_valid <= nxt == S_DISPENSE;
         if (nxt == S_DISPENSE) bus.no_items_dispensed <= qty_r;
         bus.coin_reject <= bus.coin_valid && state != S_COLLECT;
         bus.change_valid <= nxt == S_CHANGE && due_nxt != '0;
         if (nxt == S_CHANGE) bus.change_amount <= due_nxt;
         bus.err_valid <= err_nxt != ERR_NONE;
         if (err_nxt != ERR_NONE) bus.err_code <= err_nxt;
         bus.busy <= nxt != S_IDLE;
      end
   end
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed and randomized purchases against a pipelined table model
// Expected outcomes come from the purchase rules applied to whole transactions.
module tb_vend_sequencer;
   import vend_pkg::*;
   localparam int LAT = 3;
   localparam int TO = 1000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   vend_sequencer_if bus ();
   vend_sequencer #(.LOOKUP_LAT(LAT), .TIMEOUT_CYC(TO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   int n_cmp = 0, n_bad = 0;
   // table: stock/price memory read through a three-stage pipeline, decremented by dispenses
   logic [7:0] stock_t[16], price_t[16], init_stock[16], init_price[16];
   logic [7:0] a0, a1, p0, p1;
   logic tbl_load = 1'b0;
   int stock_m[16], price_m[16];
   int plan[$];
   always @(posedge clk) begin
      if (tbl_load) for (int i = 0; i < 16; i++) begin
         stock_t[i] <= init_stock[i];
         price_t[i] <= init_price[i];
      end else if (bus.dispense_valid)
         stock_t[bus.item_id[3:0]] <= stock_t[bus.item_id[3:0]] - bus.no_items_dispensed;
      a0 <= stock_t[bus.item_id[3:0]];
      a1 <= a0;
      bus.avail_count <= a1;
      p0 <= price_t[bus.item_id[3:0]];
      p1 <= p0;
      bus.item_price <= p1;
   end
   int n_disp = 0, n_chg = 0, n_err = 0, n_rej = 0, n_wide = 0;
   logic [7:0] last_qty;
   logic [15:0] last_chg;
   logic [1:0] last_err;
   logic pd = 1'b0, pc = 1'b0, pe = 1'b0;
   always @(negedge clk) begin
      if (bus.dispense_valid) begin n_disp++; last_qty = bus.no_items_dispensed; end
      if (bus.change_valid) begin n_chg++; last_chg = bus.change_amount; end
      if (bus.err_valid) begin n_err++; last_err = bus.err_code; end
      if (bus.coin_reject) n_rej++;
      if ((pd && bus.dispense_valid) || (pc && bus.change_valid) || (pe && bus.err_valid)) n_wide++;
      pd = bus.dispense_valid;
      pc = bus.change_valid;
      pe = bus.err_valid;
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic coin(input int v);
      bus.coin_valid = 1'b1;
      bus.coin_value = 8'(v);
      cyc(1);
      bus.coin_valid = 1'b0;
   endtask
   // abort: 0 none, 1 cancel, 2 cfg_mode; coins come from plan first, then random
   task automatic txn(input string tag, input int id, input int qty, input int abort,
                      input bit early, input bit extra_sel);
      int cost, paid, d0, c0, e0, r0, w0, exp_disp, exp_chg, exp_err, v, lim, k;
      cost = price_m[id] * qty;
      paid = 0;
      exp_disp = 0;
      exp_chg = 0;
      exp_err = 0;
      d0 = n_disp; c0 = n_chg; e0 = n_err; r0 = n_rej; w0 = n_wide;
      bus.sel_id = 10'(id);
      bus.sel_qty = 8'(qty);
      bus.sel_valid = 1'b1;
      cyc(1);
      bus.sel_valid = 1'b0;
      if (early) coin($urandom_range(1, 9));
      if (qty == 0) exp_err = 2;
      else if (qty > stock_m[id]) exp_err = 1;
      else if (cost == 0) exp_disp = 1;
      else begin
         cyc(early ? 4 : 5);
         if (extra_sel) begin
            bus.sel_id = 10'((id + 1) % 16);
            bus.sel_qty = 8'(qty + 1);
            bus.sel_valid = 1'b1;
            cyc(1);
            bus.sel_valid = 1'b0;
         end
         if (abort == 0) begin
            while (paid < cost) begin
               v = plan.size() > 0 ? plan.pop_front() : int'($urandom_range(1, 60));
               paid = paid + v > 65535 ? 65535 : paid + v;
               coin(v);
            end
            exp_disp = 1;
            exp_chg = paid - cost;
         end else begin
            if (plan.size() > 0) while (plan.size() > 0) begin
               v = plan.pop_front();
               paid += v;
               coin(v);
            end else begin
               k = $urandom_range(0, 3);
               for (int i = 0; i < k; i++) begin
                  lim = cost - 1 - paid;
                  if (lim < 1) break;
                  v = $urandom_range(1, lim > 60 ? 60 : lim);
                  paid += v;
                  coin(v);
               end
            end
            if (abort == 1) bus.cancel = 1'b1;
            else bus.cfg_mode = 1'b1;
            cyc(1);
            bus.cancel = 1'b0;
            bus.cfg_mode = 1'b0;
            exp_err = 3;
            exp_chg = paid;
         end
      end
      if (exp_disp == 1) stock_m[id] -= qty;
      for (int i = 0; i < 300 && bus.busy; i++) cyc(1);
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_return got %b want 0", tag, bus.busy); end
      cyc(3);
      n_cmp++;
      if (n_disp - d0 !== exp_disp) begin n_bad++; $display("FAIL %s dispense_count got %0d want %0d", tag, n_disp - d0, exp_disp); end
      if (exp_disp == 1) begin
         n_cmp++;
         if (int'(last_qty) !== qty) begin n_bad++; $display("FAIL %s dispense_qty got %0d want %0d", tag, last_qty, qty); end
      end
      n_cmp++;
      if (n_chg - c0 !== int'(exp_chg != 0)) begin n_bad++; $display("FAIL %s change_count got %0d want %0d", tag, n_chg - c0, exp_chg != 0); end
      if (exp_chg != 0) begin
         n_cmp++;
         if (int'(last_chg) !== exp_chg) begin n_bad++; $display("FAIL %s change_amount got %0d want %0d", tag, last_chg, exp_chg); end
      end
      n_cmp++;
      if (n_err - e0 !== int'(exp_err != 0)) begin n_bad++; $display("FAIL %s err_count got %0d want %0d", tag, n_err - e0, exp_err != 0); end
      if (exp_err != 0) begin
         n_cmp++;
         if (int'(last_err) !== exp_err) begin n_bad++; $display("FAIL %s err_code got %0d want %0d", tag, last_err, exp_err); end
      end
      n_cmp++;
      if (int'(stock_t[id]) !== stock_m[id]) begin n_bad++; $display("FAIL %s table_stock got %0d want %0d", tag, stock_t[id], stock_m[id]); end
      n_cmp++;
      if (n_rej - r0 !== int'(early)) begin n_bad++; $display("FAIL %s coin_reject_count got %0d want %0d", tag, n_rej - r0, early); end
      n_cmp++;
      if (n_wide !== w0) begin n_bad++; $display("FAIL %s strobe_width got %0d long pulses want 0", tag, n_wide - w0); end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      cyc(3);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.item_id !== '0) begin n_bad++; $display("FAIL reset_state busy=%b item_id=%0d want 0/0", bus.busy, bus.item_id); end
      n_cmp++;
      if ({bus.dispense_valid, bus.coin_reject, bus.change_valid, bus.err_valid} !== 4'b0) begin
         n_bad++; $display("FAIL reset_strobes got %b want 0000", {bus.dispense_valid, bus.coin_reject, bus.change_valid, bus.err_valid});
      end
      n_cmp++;
      if (bus.no_items_dispensed !== '0 || bus.change_amount !== '0 || bus.err_code !== 2'd0) begin
         n_bad++; $display("FAIL reset_data qty=%0d chg=%0d err=%0d want 0", bus.no_items_dispensed, bus.change_amount, bus.err_code);
      end
      rst = 1'b0;
      cyc(1);
   endtask
   task automatic test_exact;
      plan = '{5, 5};
      txn("exact", 0, 2, 0, 1'b0, 1'b0);
      n_cmp++;
      if (stock_t[0] !== 8'd1) begin n_bad++; $display("FAIL exact_table_avail got %0d want 1", stock_t[0]); end
   endtask
   task automatic test_overpay;
      plan = '{10};
      txn("overpay", 1, 1, 0, 1'b0, 1'b0);
   endtask
   task automatic test_sold_out;
      txn("sold_out", 2, 2, 0, 1'b0, 1'b0);
   endtask
   task automatic test_cancel;
      plan = '{5, 5};
      txn("cancel", 3, 1, 1, 1'b0, 1'b0);
      txn("cfg_abort", 3, 1, 2, 1'b0, 1'b0);
   endtask
   task automatic test_timeout;
      int e0, c0, d0;
      e0 = n_err; c0 = n_chg; d0 = n_disp;
      bus.sel_id = 10'd3;
      bus.sel_qty = 8'd1;
      bus.sel_valid = 1'b1;
      cyc(1);
      bus.sel_valid = 1'b0;
      cyc(5);
      coin(5);
      cyc(TO - 1);
      n_cmp++;
      if (bus.err_valid !== 1'b0 || n_err != e0 || bus.busy !== 1'b1) begin
         n_bad++; $display("FAIL timeout_early err_valid=%b errs=%0d busy=%b want 0/0/1", bus.err_valid, n_err - e0, bus.busy);
      end
      for (int i = 0; i < 50 && bus.busy; i++) cyc(1);
      cyc(3);
      n_cmp++;
      if (n_err - e0 !== 1 || last_err !== 2'd3) begin n_bad++; $display("FAIL timeout_err count=%0d code=%0d want 1/3", n_err - e0, last_err); end
      n_cmp++;
      if (n_chg - c0 !== 1 || last_chg !== 16'd5) begin n_bad++; $display("FAIL timeout_refund count=%0d amount=%0d want 1/5", n_chg - c0, last_chg); end
      n_cmp++;
      if (n_disp !== d0) begin n_bad++; $display("FAIL timeout_dispense got %0d want 0", n_disp - d0); end
   endtask
   task automatic test_misc;
      int r0, d0, c0, e0;
      r0 = n_rej;
      coin(7);
      cyc(2);
      n_cmp++;
      if (n_rej - r0 !== 1) begin n_bad++; $display("FAIL idle_coin_reject got %0d want 1", n_rej - r0); end
      txn("bad_qty", 0, 0, 0, 1'b0, 1'b0);
      txn("lookup_coin", 1, 1, 0, 1'b1, 1'b0);
      bus.cfg_mode = 1'b1;
      bus.sel_id = 10'd1;
      bus.sel_qty = 8'd1;
      bus.sel_valid = 1'b1;
      cyc(1);
      bus.sel_valid = 1'b0;
      cyc(2);
      n_cmp++;
      if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL cfg_blocks_sel busy got %b want 0", bus.busy); end
      bus.cfg_mode = 1'b0;
      cyc(1);
      bus.sel_id = 10'd3;
      bus.sel_valid = 1'b1;
      cyc(1);
      bus.sel_valid = 1'b0;
      cyc(5);
      coin(5);
      d0 = n_disp; c0 = n_chg; e0 = n_err;
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(10);
      n_cmp++;
      if (n_disp != d0 || n_chg != c0 || n_err != e0) begin
         n_bad++; $display("FAIL rst_collect_strobes disp=%0d chg=%0d err=%0d want 0", n_disp - d0, n_chg - c0, n_err - e0);
      end
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.item_id !== '0 || bus.change_amount !== '0 || bus.no_items_dispensed !== '0) begin
         n_bad++; $display("FAIL rst_collect_state busy=%b id=%0d chg=%0d qty=%0d want 0", bus.busy, bus.item_id, bus.change_amount, bus.no_items_dispensed);
      end
   endtask
   task automatic test_back_to_back;
      txn("b2b_a", 1, 2, 0, 1'b0, 1'b1);
      txn("b2b_b", 1, 1, 0, 1'b0, 1'b0);
   endtask
   task automatic test_random;
      int id, qty, ab;
      for (int n = 0; n < 30; n++) begin
         id = $urandom_range(0, 15);
         qty = $urandom_range(0, 6);
         ab = $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0;
         txn("random", id, qty, ab, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
      end
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      bus.cfg_mode = 1'b0;
      bus.sel_valid = 1'b0;
      bus.sel_id = '0;
      bus.sel_qty = '0;
      bus.coin_valid = 1'b0;
      bus.coin_value = '0;
      bus.cancel = 1'b0;
      for (int i = 0; i < 16; i++) begin
         init_price[i] = $urandom_range(0, 9) == 0 ? 8'd0 : 8'($urandom_range(1, 40));
         init_stock[i] = 8'($urandom_range(0, 20));
      end
      init_price[0] = 8'd5; init_stock[0] = 8'd3;
      init_price[1] = 8'd7; init_stock[1] = 8'd9;
      init_price[2] = 8'd4; init_stock[2] = 8'd1;
      init_price[3] = 8'd20; init_stock[3] = 8'd5;
      for (int i = 0; i < 16; i++) begin
         price_m[i] = int'(init_price[i]);
         stock_m[i] = int'(init_stock[i]);
      end
      tbl_load = 1'b1;
      cyc(2);
      tbl_load = 1'b0;
      test_reset;
      test_exact;
      test_overpay;
      test_sold_out;
      test_cancel;
      test_timeout;
      test_misc;
      test_back_to_back;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
